map_loader: RTL and testbench

MAP_LOADER -- requirements
Module: map_loader

---
 rtl/map_pkg.sv | 44 ++++
 rtl/map_loader.sv | 108 ++++++++++
 tb/tb_map_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// map_pkg: tile codes, map geometry and small helpers shared by the map logic.
// Also holds the FSM state type for map_loader.
package map_pkg;

  localparam int MAP_W       = 15;
  localparam int MAP_H       = 10;
  localparam int TILE_BITS   = 4;
  localparam int TILE_COUNT  = 150;
  localparam int LEVEL_COUNT = 4;
  localparam int MAP_BITS    = TILE_COUNT * TILE_BITS;

  localparam logic [3:0] T_BLANK   = 4'd0;
  localparam logic [3:0] T_WALL    = 4'd1;
  localparam logic [3:0] T_COIN    = 4'd2;
  localparam logic [3:0] T_POWERUP = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_e;

  function automatic logic [3:0] tile_sanitize(
    input logic [3:0] v
  );
    return (v > T_POWERUP) ? T_BLANK : v;
  endfunction

  function automatic logic [9:0] lvl_base(
    input logic [1:0] l
  );
    return 10'(l) * 10'd150;
  endfunction

  function automatic logic is_border(
    input logic [7:0] i
  );
    logic [7:0] x;
    x = i % 8'd15;
    return (x == 8'd0) || (x == 8'd14) ||
           (i < 8'd15) || (i >= 8'd135);
  endfunction

endpackage

// File: rtl/map_loader.sv
// map_loader: streams a 15x10 level from an external tile ROM into a flat map
// and services pickup clears. Define MAP_LOADER_BORDER_EN to force a WALL rim.
module map_loader
  import map_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic [1:0]          level_sel,
  output logic [9:0]          rom_addr,
  input  logic [3:0]          rom_data,
  input  logic                clr_req,
  input  logic [3:0]          clr_x,
  input  logic [3:0]          clr_y,
  output logic [MAP_BITS-1:0] map,
  output logic                busy,
  output logic                ready,
  output logic [7:0]          coins_left,
  output logic                level_clear
);

  state_e              state_q;
  logic [9:0]          base_q;
  logic [9:0]          rom_addr_q;
  logic [7:0]          cnt_q;
  logic [7:0]          coins_q;
  logic [MAP_BITS-1:0] map_q;
  logic                busy_q;
  logic                ready_q;
  logic                lvl_clr_q;

  logic [7:0] wr_idx;
  logic [7:0] clr_idx;
  logic [3:0] tile_in;
  logic [3:0] clr_tile;
  logic       clr_ok;

  // cnt_q == n issues tile n and writes tile n-1 (ROM data lags by one)
  always_comb begin
    wr_idx  = cnt_q - 8'd1;
    tile_in = tile_sanitize(rom_data);
`ifdef MAP_LOADER_BORDER_EN
    if (is_border(wr_idx)) tile_in = T_WALL;
`endif
    clr_idx  = {4'd0, clr_x} + 8'd15 * {4'd0, clr_y};
    clr_tile = map_q[{clr_idx, 2'b00} +: TILE_BITS];
    clr_ok   = clr_req &&
               (clr_x <= 4'd14) && (clr_y <= 4'd9) &&
               (clr_tile == T_COIN || clr_tile == T_POWERUP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      coins_q    <= '0;
      map_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      lvl_clr_q  <= 1'b0;
    end else begin
      lvl_clr_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (load_req) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            coins_q <= '0;
            cnt_q   <= '0;
            base_q  <= lvl_base(level_sel);
          end else if (state_q == S_DONE && clr_ok) begin
            map_q[{clr_idx, 2'b00} +: TILE_BITS] <= T_BLANK;
            if (clr_tile == T_COIN && coins_q != 8'd0) begin
              coins_q <= coins_q - 8'd1;
              if (coins_q == 8'd1) lvl_clr_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (cnt_q < 8'(TILE_COUNT))
            rom_addr_q <= base_q + {2'b00, cnt_q};
          if (cnt_q != 8'd0) begin
            map_q[{wr_idx, 2'b00} +: TILE_BITS] <= tile_in;
            if (tile_in == T_COIN) coins_q <= coins_q + 8'd1;
          end
          if (cnt_q == 8'(TILE_COUNT)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
          cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign map         = map_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign coins_left  = coins_q;
  assign level_clear = lvl_clr_q;

endmodule

// File: tb/tb_map_loader.sv
// tb_map_loader: random level ROM plus a tile-array model of the map.
// Build with MAP_LOADER_BORDER_EN to exercise the WALL rim variant.
module tb_map_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_req = 1'b0;
  logic [1:0]   level_sel = 2'd0;
  logic [9:0]   rom_addr;
  logic [3:0]   rom_data;
  logic         clr_req = 1'b0;
  logic [3:0]   clr_x = 4'd0;
  logic [3:0]   clr_y = 4'd0;
  logic [599:0] map;
  logic         busy;
  logic         ready;
  logic [7:0]   coins_left;
  logic         level_clear;

  logic [3:0] rom_mem [0:599];
  logic [3:0] m_map   [0:149];
  int         m_coins = 0;
  bit         m_done  = 0;
  int         n_vec   = 0;
  int         n_err   = 0;
  int         pulses  = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  map_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .level_sel  (level_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .clr_req    (clr_req),
    .clr_x      (clr_x),
    .clr_y      (clr_y),
    .map        (map),
    .busy       (busy),
    .ready      (ready),
    .coins_left (coins_left),
    .level_clear(level_clear)
  );

  always @(negedge clk) if (level_clear === 1'b1) pulses++;

  task automatic chk(string tag, logic [599:0] got, logic [599:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [599:0] pack_model();
    logic [599:0] r;
    r = '0;
    for (int i = 0; i < 150; i++) r[i*4 +: 4] = m_map[i];
    return r;
  endfunction

  task automatic model_load(int lvl);
    int v;
    m_coins = 0;
    for (int i = 0; i < 150; i++) begin
      v = int'(rom_mem[lvl*150 + i]);
      if (v > 3) v = 0;
`ifdef MAP_LOADER_BORDER_EN
      if (i % 15 == 0 || i % 15 == 14 || i < 15 || i >= 135) v = 1;
`endif
      m_map[i] = 4'(v);
      if (v == 2) m_coins++;
    end
    m_done = 1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 150; i++) m_map[i] = 4'd0;
    m_coins = 0;
    m_done  = 0;
  endtask

  task automatic do_clear(int x, int y);
    int idx;
    bit exp_p;
    exp_p = 0;
    if (m_done && x <= 14 && y <= 9) begin
      idx = x + 15*y;
      if (m_map[idx] == 4'd2) begin
        m_map[idx] = 4'd0;
        m_coins--;
        exp_p = (m_coins == 0);
      end else if (m_map[idx] == 4'd3) begin
        m_map[idx] = 4'd0;
      end
    end
    @(negedge clk);
    clr_req = 1'b1;
    clr_x = 4'(x);
    clr_y = 4'(y);
    @(negedge clk);
    clr_req = 1'b0;
    chk("clr_map", map, pack_model());
    chk("clr_coins", coins_left, 600'(m_coins));
    chk("clr_pulse", level_clear, 600'(exp_p));
  endtask

  // inj: cycle at which a stray load_req is raised mid-fetch (0 = none)
  task automatic run_load(int lvl, int inj, bit with_clr, bit abort);
    int cyc, addr_bad, busy_bad;
    logic [9:0] base;
    cyc = 0;
    addr_bad = 0;
    busy_bad = 0;
    base = 10'(lvl * 150);
    @(negedge clk);
    load_req  = 1'b1;
    level_sel = 2'(lvl);
    if (with_clr) begin
      clr_req = 1'b1;
      clr_x = 4'd1;
      clr_y = 4'd1;
    end
    @(negedge clk);
    load_req = 1'b0;
    clr_req  = 1'b0;
    chk("acc_busy", busy, 600'(1));
    chk("acc_ready", ready, 600'(0));
    chk("acc_coins", coins_left, 600'(0));
    while (!ready && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc <= 150 && rom_addr !== 10'(base + 10'(cyc - 1)))
        addr_bad++;
      if (!ready && busy !== 1'b1) busy_bad++;
      load_req  = (cyc == inj);
      level_sel = 2'(lvl + 1);
      if (abort && cyc == 71) begin
        load_req = 1'b0;
        chk("abort_addr", rom_addr, 600'(base + 10'd70));
        rst = 1'b1;
        return;
      end
    end
    load_req = 1'b0;
    model_load(lvl);
    chk("ready_lat", 600'(cyc), 600'(151));
    chk("addr_seq", 600'(addr_bad), 600'(0));
    chk("busy_hold", 600'(busy_bad), 600'(0));
    chk("load_map", map, pack_model());
    chk("load_coins", coins_left, 600'(m_coins));
    chk("done_busy", busy, 600'(0));
  endtask

  initial begin
    int p0;
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_map", map, '0);
    chk("rst_addr", rom_addr, '0);
    chk("rst_busy", busy, '0);
    chk("rst_ready", ready, '0);
    chk("rst_coins", coins_left, '0);
    chk("rst_lc", level_clear, '0);
    rst = 1'b0;

    for (int i = 0; i < 600; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 300; i < 450; i++)
      if (rom_mem[i] == 4'd2) rom_mem[i] = 4'd0;
    rom_mem[300 + 48]  = 4'd2;
    rom_mem[300 + 82]  = 4'd2;
    rom_mem[300 + 132] = 4'd2;
    rom_mem[300 + 80]  = 4'd3;
    rom_mem[300 + 32]  = 4'd1;
    rom_mem[0]         = 4'd2;
    rom_mem[16]        = 4'd2;

    run_load(1, 0, 0, 0);
    chk("ready_hi", ready, 600'(1));
    for (int k = 0; k < 30; k++)
      do_clear($urandom_range(0, 15), $urandom_range(0, 15));

    run_load(2, 0, 0, 0);
    chk("three_coins", coins_left, 600'(3));
    do_clear(15, 2);
    do_clear(3, 10);
    do_clear(2, 2);
    chk("bad_clr_coins", coins_left, 600'(3));
    do_clear(5, 5);
    p0 = pulses;
    do_clear(3, 3);
    do_clear(3, 3);
    do_clear(7, 5);
    do_clear(12, 8);
    @(negedge clk);
    chk("lc_low", level_clear, 600'(0));
    chk("lc_once", 600'(pulses - p0), 600'(1));
    chk("no_underflow", coins_left, 600'(0));
    do_clear(12, 8);

    run_load(0, 40, 0, 0);
`ifdef MAP_LOADER_BORDER_EN
    chk("border_00", map[3:0], 600'(1));
`else
    chk("plain_00", map[3:0], 600'(2));
`endif
    chk("coin_11", map[16*4 +: 4], 600'(2));

    run_load(3, 0, 1, 0);

    run_load(1, 0, 0, 1);
    #1;
    model_reset();
    chk("abt_map", map, '0);
    chk("abt_addr", rom_addr, '0);
    chk("abt_busy", busy, '0);
    chk("abt_ready", ready, '0);
    chk("abt_coins", coins_left, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy, '0);
    chk("idle_addr", rom_addr, '0);
    do_clear(3, 3);
    chk("idle_ready", ready, '0);

    run_load(2, 0, 0, 0);
    do_clear(7, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
